// File: rtl/imm_materializer.sv
// Turns a 32-bit constant into the shortest RV32I sequence (ADDI, LUI, or LUI+ADDI)
// and streams the words out over a valid/ready handshake, one word per request slot.
module imm_materializer #(
    parameter int EN_SHORT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LUI  = 2'd1,
        EMIT_ADDI = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;

    function automatic logic [31:0] enc_lui(input logic [19:0] upper, input logic [4:0] rd);
        return {upper, rd, OP_LUI};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, OP_OP_IMM};
    endfunction

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [11:0] lo_q, lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        has_addi_q, has_addi_d;

    logic        accept, out_hs;
    logic        fits_addi, fits_lui;
    logic [19:0] upper_rnd;

    assign accept = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    // ADDI sign-extends bit 11, so the pair form pre-rounds the upper part by that bit.
    assign fits_addi = (EN_SHORT != 0) &&
                       ((in_value[31:11] == '0) || (in_value[31:11] == '1));
    assign fits_lui  = (EN_SHORT != 0) && (in_value[11:0] == 12'h000);
    assign upper_rnd = in_value[31:12] + {19'd0, in_value[11]};

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_instr_d = out_instr_q;
        lo_d        = lo_q;
        rd_d        = rd_q;
        has_addi_d  = has_addi_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (accept) begin
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    lo_d        = in_value[11:0];
                    rd_d        = in_rd;
                    if (fits_addi) begin
                        state_d     = EMIT_ADDI;
                        out_instr_d = enc_addi(in_value[11:0], 5'd0, in_rd);
                        out_last_d  = 1'b1;
                        has_addi_d  = 1'b0;
                    end else if (fits_lui) begin
                        state_d     = EMIT_LUI;
                        out_instr_d = enc_lui(in_value[31:12], in_rd);
                        out_last_d  = 1'b1;
                        has_addi_d  = 1'b0;
                    end else begin
                        state_d     = EMIT_LUI;
                        out_instr_d = enc_lui(upper_rnd, in_rd);
                        out_last_d  = 1'b0;
                        has_addi_d  = 1'b1;
                    end
                end
            end

            EMIT_LUI: begin
                in_ready_d = 1'b0;
                if (out_hs) begin
                    if (has_addi_q) begin
                        state_d     = EMIT_ADDI;
                        out_instr_d = enc_addi(lo_q, rd_q, rd_q);
                        out_last_d  = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
            end

            EMIT_ADDI: begin
                in_ready_d = 1'b0;
                if (out_hs) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b0;
            end
        endcase
    end

    // in_ready is registered so it first rises one edge after reset or after the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_instr_q <= 32'd0;
            lo_q        <= 12'd0;
            rd_q        <= 5'd0;
            has_addi_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_instr_q <= out_instr_d;
            lo_q        <= lo_d;
            rd_q        <= rd_d;
            has_addi_q  <= has_addi_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_materializer.sv
// Bench for imm_materializer: directed table, stall/reset sequences, and random
// constants checked against an arithmetic reference model.
module tb_imm_materializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    imm_materializer #(.EN_SHORT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_rd    (in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic [4:0]  rd;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Reference: pick the form from the numeric range of the constant, encode by arithmetic.
    task automatic ref_words(input logic [31:0] v, input logic [4:0] rd,
                             output int n, output logic [31:0] w0, output logic [31:0] w1);
        longint sv;
        longint unsigned upper, imm;
        sv    = longint'($signed(v));
        imm   = longint'(v) % 4096;
        upper = ((longint'(v) + 2048) % 64'h1_0000_0000) / 4096;
        w1    = 32'd0;
        if (sv >= -2048 && sv <= 2047) begin
            n  = 1;
            w0 = 32'(imm * (1 << 20) + rd * 128 + 19);
        end else if (imm == 0) begin
            n  = 1;
            w0 = 32'((longint'(v) / 4096) * 4096 + rd * 128 + 55);
        end else begin
            n  = 2;
            w0 = 32'(upper * 4096 + rd * 128 + 55);
            w1 = 32'(imm * (1 << 20) + rd * 32768 + rd * 128 + 19);
        end
    endtask

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic do_req(input logic [31:0] v, input logic [4:0] rd, input int stall,
                          input int n, input logic [31:0] e0, input logic [31:0] e1);
        int t;
        logic [31:0] exp;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_value = v; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; in_value = $urandom; in_rd = 5'($urandom);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            exp = (i == 0) ? e0 : e1;
            for (int s = 0; s < stall; s++) begin
                chk("stall_instr", out_instr, exp);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
            end
            chk("instr", out_instr, exp);
            chk("last", 32'(out_last), 32'(i == n - 1));
            chk("valid", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] w0, w1, v;
        logic [4:0] rd;

        tbl[0] = '{32'h00000005, 5'd10, 1, 32'h00500513, 32'h0};
        tbl[1] = '{32'h12345678, 5'd5,  2, 32'h123452B7, 32'h67828293};
        tbl[2] = '{32'h00000800, 5'd1,  2, 32'h000010B7, 32'h80008093};
        tbl[3] = '{32'hFFFFF800, 5'd2,  1, 32'h80000113, 32'h0};
        tbl[4] = '{32'h00003000, 5'd3,  1, 32'h000031B7, 32'h0};
        tbl[5] = '{32'h12345678, 5'd0,  2, 32'h12345037, 32'h67800013};
        tbl[6] = '{32'h000007FF, 5'd31, 1, 32'h7FF00F93, 32'h0};
        tbl[7] = '{32'hFFFFFFFF, 5'd4,  1, 32'hFFF00213, 32'h0};
        tbl[8] = '{32'h7FFFF800, 5'd6,  2, 32'h80000337, 32'h80030313};
        tbl[9] = '{32'hFFFFF7FF, 5'd7,  2, 32'hFFFFF3B7, 32'h7FF38393};

        rst = 1'b1; in_valid = 1'b0; in_value = '0; in_rd = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1 chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 10; i++)
            do_req(tbl[i].v, tbl[i].rd, i % 2, tbl[i].n, tbl[i].w0, tbl[i].w1);

        // Backpressure on the first word of a pair, then order on release.
        do_req(32'h12345678, 5'd5, 3, 2, 32'h123452B7, 32'h67828293);

        // Reset while the ADDI half of a pair is pending.
        in_valid = 1'b1; in_value = 32'h12345678; in_rd = 5'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pend_instr", out_instr, 32'h67828293);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("no_stale_valid", 32'(out_valid), 32'd0);
        do_req(32'h00000005, 5'd10, 0, 1, 32'h00500513, 32'h0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: v = 32'($signed(12'($urandom)));
                1: v = {$urandom, 12'h000} ;
                2: v = {20'($urandom), 12'h800};
                default: v = $urandom;
            endcase
            rd = 5'($urandom);
            ref_words(v, rd, n, w0, w1);
            do_req(v, rd, $urandom_range(0, 2), n, w0, w1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
